// File: rtl/arbitro_serializador.sv
// Round-robin arbiter feeding a single LSB-first PISO serializer shared by N_REQ
// parallel-word requesters, with GAP idle cycles inserted after every frame.
module arbitro_serializador #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       serial_out,
  output logic                       serial_valid,
  output logic                       frame_start,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(WIDTH);
  localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0]  CLAST    = CW'(WIDTH - 1);
  localparam logic [GW-1:0]  GLAST    = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_shreg;
  logic [CW-1:0]        r_cnt;
  logic [GW-1:0]        r_gcnt;
  logic [IDW-1:0]       r_last;
  logic [IDW-1:0]       r_grant;

  logic                 w_any;
  logic [IDW-1:0]       w_win;
  logic [IDW-1:0]       w_idx;
  logic [WIDTH-1:0]     w_word;

  // First valid requester found scanning last+1, last+2, ... modulo N_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = IDW'((32'(r_last) + k) % N_REQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_word = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CLAST) w_next = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gcnt == GLAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters are cleared on the way into the state that uses them, so neither wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_last  <= LAST_RST;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_shreg <= w_word;
            r_grant <= w_win;
            r_last  <= w_win;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          r_shreg <= r_shreg >> 1;
          if (r_cnt == CLAST) begin
            r_cnt  <= '0;
            r_gcnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          r_gcnt <= r_gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && (r_state == S_IDLE) && w_any) begin
      req_ready[w_win] = 1'b1;
    end
    serial_valid = (r_state == S_SHIFT);
    serial_out   = (r_state == S_SHIFT) && r_shreg[0];
    frame_start  = (r_state == S_SHIFT) && (r_cnt == '0);
    busy         = (r_state != S_IDLE);
    grant_id     = r_grant;
  end

endmodule

// File: tb/tb_arbitro_serializador.sv
// Bench for arbitro_serializador: a GAP=1 and a GAP=0 instance, a directed vector
// table, multi-cycle sequences, and random traffic against a frame-position model.
module tb_arbitro_serializador;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld [2];
  logic [15:0] dat [2];
  logic [3:0]  rdy [2];
  logic        so  [2];
  logic        sv  [2];
  logic        fs  [2];
  logic [1:0]  gid [2];
  logic        bz  [2];

  always #5 clk = ~clk;

  arbitro_serializador #(.N_REQ(4), .WIDTH(4), .GAP(1)) u_gap1 (
    .clk(clk), .reset(rst), .req_valid(vld[0]), .req_data(dat[0]),
    .req_ready(rdy[0]), .serial_out(so[0]), .serial_valid(sv[0]),
    .frame_start(fs[0]), .grant_id(gid[0]), .busy(bz[0])
  );

  arbitro_serializador #(.N_REQ(4), .WIDTH(4), .GAP(0)) u_gap0 (
    .clk(clk), .reset(rst), .req_valid(vld[1]), .req_data(dat[1]),
    .req_ready(rdy[1]), .serial_out(so[1]), .serial_valid(sv[1]),
    .frame_start(fs[1]), .grant_id(gid[1]), .busy(bz[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: position in the frame timeline. 0 = idle, 1..4 = bit pos-1 on the
  // wire, 5..4+GAP = idle gap.
  int         m_gap  [2] = '{1, 0};
  int         m_pos  [2] = '{0, 0};
  int         m_last [2] = '{3, 3};
  int         m_grant[2] = '{0, 0};
  logic [3:0] m_word [2];

  int q_id0[$], q_cyc0[$], q_id1[$], q_cyc1[$];
  logic last_sv0;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  rdy;
    logic        so, sv, fs;
    logic [1:0]  gid;
    logic        bz;
  } vec_t;
  vec_t tbl [15];

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int winner(int k);
    for (int j = 1; j <= 4; j++) begin
      int idx;
      idx = (m_last[k] + j) % 4;
      if (vld[k][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_check(int k);
    int w, er, sh;
    w  = winner(k);
    er = (rst || m_pos[k] != 0 || w < 0) ? 0 : (1 << w);
    sh = (m_pos[k] >= 1 && m_pos[k] <= 4) ? 1 : 0;
    check($sformatf("g%0d_ready", k), int'(rdy[k]), er);
    check($sformatf("g%0d_svalid", k), int'(sv[k]), sh);
    check($sformatf("g%0d_sout", k), int'(so[k]), sh ? int'(m_word[k][m_pos[k]-1]) : 0);
    check($sformatf("g%0d_fstart", k), int'(fs[k]), (m_pos[k] == 1) ? 1 : 0);
    check($sformatf("g%0d_grant", k), int'(gid[k]), m_grant[k]);
    check($sformatf("g%0d_busy", k), int'(bz[k]), (m_pos[k] != 0) ? 1 : 0);
  endtask

  task automatic model_advance(int k);
    int w;
    if (rst) begin
      m_pos[k] = 0; m_last[k] = 3; m_grant[k] = 0; m_word[k] = '0;
    end else if (m_pos[k] == 0) begin
      w = winner(k);
      if (w >= 0) begin
        m_word[k] = dat[k][4*w +: 4];
        m_grant[k] = w; m_last[k] = w; m_pos[k] = 1;
      end
    end else begin
      m_pos[k] = (m_pos[k] == 4 + m_gap[k]) ? 0 : m_pos[k] + 1;
    end
  endtask

  // Called at the sampling point; logs handshakes, advances the model, crosses the edge.
  task automatic finish_cycle();
    for (int b = 0; b < 4; b++) begin
      if (!rst && vld[0][b] && rdy[0][b]) begin q_id0.push_back(b); q_cyc0.push_back(cyc); end
      if (!rst && vld[1][b] && rdy[1][b]) begin q_id1.push_back(b); q_cyc1.push_back(cyc); end
    end
    last_sv0 = sv[0];
    model_advance(0);
    model_advance(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check(0);
    model_check(1);
    finish_cycle();
  endtask

  initial begin
    m_word[0] = '0;
    m_word[1] = '0;
    vld[0] = 4'hF; vld[1] = 4'h0;
    dat[0] = 16'h000B; dat[1] = 16'h0;

    tbl[0]  = '{1'b1, 4'hF, 16'h000B, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 16'h000B, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 16'h000B, 4'h1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'h1, 16'h000B, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 4'h1, 16'h000B, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 4'h1, 16'h000B, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 4'h1, 16'h000B, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[7]  = '{1'b0, 4'h1, 16'h000B, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 4'h1, 16'h000B, 4'h1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 16'h0004, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 16'h0004, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 16'h0004, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 16'h0004, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 16'h0004, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 16'h0004, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

    @(posedge clk);
    #1;

    // Directed table: reset with all valid, then two single frames of 4'b1011.
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].r; vld[0] = tbl[i].v; dat[0] = tbl[i].d;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), int'(rdy[0]), int'(tbl[i].rdy));
      check($sformatf("tbl%0d_sout", i), int'(so[0]), int'(tbl[i].so));
      check($sformatf("tbl%0d_svalid", i), int'(sv[0]), int'(tbl[i].sv));
      check($sformatf("tbl%0d_fstart", i), int'(fs[0]), int'(tbl[i].fs));
      check($sformatf("tbl%0d_grant", i), int'(gid[0]), int'(tbl[i].gid));
      check($sformatf("tbl%0d_busy", i), int'(bz[0]), int'(tbl[i].bz));
      model_check(1);
      finish_cycle();
    end

    // Full load on both instances; GAP=0 instance data churns every cycle.
    rst = 1'b1; vld[0] = 4'h0; vld[1] = 4'h0;
    tick();
    rst = 1'b0;
    q_id0.delete(); q_cyc0.delete(); q_id1.delete(); q_cyc1.delete();
    vld[0] = 4'hF; dat[0] = 16'h8421; vld[1] = 4'b0011;
    for (int t = 0; t < 40 && q_id0.size() < 5; t++) begin
      dat[1] = 16'($urandom);
      tick();
    end
    check("fl_accepts_g1", q_id0.size() >= 5 ? 5 : q_id0.size(), 5);
    check("fl_accepts_g0", q_id1.size() >= 4 ? 4 : q_id1.size(), 4);
    if (q_id0.size() >= 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("fl_order%0d", i), q_id0[i], i % 4);
      for (int i = 0; i < 4; i++) check($sformatf("fl_period%0d", i), q_cyc0[i+1] - q_cyc0[i], 6);
    end
    if (q_id1.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("g0_order%0d", i), q_id1[i], i % 2);
      for (int i = 0; i < 3; i++) check($sformatf("g0_period%0d", i), q_cyc1[i+1] - q_cyc1[i], 5);
    end

    // Fairness: grant 2, then hold 4'b1001 -> 3 then 0.
    vld[1] = 4'h0;
    q_id0.delete(); q_cyc0.delete();
    vld[0] = 4'b0100;
    for (int t = 0; t < 20 && q_id0.size() < 1; t++) tick();
    vld[0] = 4'b1001;
    for (int t = 0; t < 20 && q_id0.size() < 3; t++) tick();
    check("fair_accepts", q_id0.size() >= 3 ? 3 : q_id0.size(), 3);
    if (q_id0.size() >= 3) begin
      check("fair_first", q_id0[0], 2);
      check("fair_second", q_id0[1], 3);
      check("fair_third", q_id0[2], 0);
    end

    // Reset after the second bit of requester 1's frame.
    q_id0.delete(); q_cyc0.delete();
    vld[0] = 4'b0010; dat[0] = 16'h00F0;
    for (int t = 0; t < 20 && q_id0.size() < 1; t++) tick();
    check("mid_grant", q_id0.size() >= 1 ? q_id0[0] : -1, 1);
    vld[0] = 4'h0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; vld[0] = 4'b1010;
    tick();
    check("mid_abort_svalid", int'(last_sv0), 0);
    check("mid_regrant", q_id0.size() >= 2 ? q_id0[1] : -1, 1);

    // Random traffic with occasional resets on both instances.
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 63) == 0);
      vld[0] = 4'($urandom); vld[1] = 4'($urandom);
      dat[0] = 16'($urandom); dat[1] = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitro_serializador.md
# arbitro_serializador

Round-robin scheduler that shares one PISO serializer between `N_REQ` parallel-word requesters. Each requester presents a `WIDTH`-bit word with a valid/ready handshake. The block grants one requester, loads its word, and shifts it out LSB-first, one bit per cycle. It inserts `GAP` idle cycles between frames. It sits between the parallel producers and the serial link, and it owns all load/shift sequencing of the shift register.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 4, bits per word (≥2)
- `GAP`, 1, idle cycles after each frame (≥0)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  requester i has a word pending
- `req_data`  in  N_REQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- `req_ready`  out  N_REQ  one-hot accept; transfer when `req_valid[i] && req_ready[i]`
- `serial_out`  out  1  serialized bit
- `serial_valid`  out  1  `serial_out` carries a frame bit
- `frame_start`  out  1  high with bit 0 of each frame
- `grant_id`  out  clog2(N_REQ)  requester whose frame is being shifted
- `busy`  out  1  high in any state except IDLE

## Operation
- Uses one clock, `clk`. Reset is synchronous and active-high on `reset`.
- State machine states: IDLE, SHIFT, GAP_WAIT.
- IDLE:
  - If no `req_valid` bit is set, remain in IDLE.
  - Otherwise pick winner w by round-robin. Search order is `last+1`, `last+2`, … mod N_REQ.
  - Drive `req_ready[w]=1` combinationally. Exactly one bit of `req_ready` is high, and only in IDLE.
  - At the edge:
    - `shreg <= req_data[w]`
    - `grant_id <= w`
    - `last <= w`
    - `cnt <= 0`
    - go to SHIFT.
- SHIFT:
  - `serial_valid=1`, `serial_out=shreg[0]`, `frame_start=(cnt==0)`.
  - Each edge: `shreg <= shreg>>1` (zero fill), `cnt <= cnt+1`.
  - When `cnt==WIDTH-1`:
    - if GAP>0, go to GAP_WAIT with `gcnt <= 0`;
    - else go to IDLE.
- GAP_WAIT:
  - All serial outputs are low.
  - `gcnt` increments each cycle.
  - When `gcnt==GAP-1`, go to IDLE.
- `req_ready` is all-zero in SHIFT and GAP_WAIT. Requests are held by the requesters, not queued internally.
- `req_data` is sampled only at the accept edge. Changes during SHIFT do not affect the frame in flight.
- A requester may drop `req_valid` before it is granted. The drop has no side effects.
- `cnt` is clog2(WIDTH) bits wide and `gcnt` is clog2(GAP) bits wide, or absent when GAP=0. Neither counter wraps: both are reset on state entry.
- Reset values:
  - state IDLE
  - `shreg=0`, `cnt=0`, `gcnt=0`
  - `last=N_REQ-1`, so requester 0 has first priority
  - `grant_id=0`
  - `serial_out=0`, `serial_valid=0`, `frame_start=0`, `busy=0`
  - `req_ready` all 0 during the reset cycle
- Reset mid-frame aborts the frame at once. No remaining bits are emitted, and the partially sent frame is not replayed.

## Timing
- Accept edge E is an IDLE cycle with a handshake.
- Cycles E+1 … E+WIDTH: `serial_valid=1`, carrying bits d[0] … d[WIDTH-1] in that order. `frame_start` is high in cycle E+1 only.
- Cycles E+WIDTH+1 … E+WIDTH+GAP: GAP_WAIT.
- Next possible accept is in cycle E+WIDTH+GAP+1.
- Minimum frame period under continuous demand is WIDTH+GAP+1 cycles. With defaults this is 6.
- `serial_out`, `serial_valid`, `frame_start` and `grant_id` are registered or state-decoded, with no combinational path from the inputs.
- `req_ready` is combinational from `req_valid`, `last` and state.
- `busy` is high from E+1 through the last GAP_WAIT cycle.

## Test plan
- **Reset:** assert `reset` 2 cycles with all `req_valid=1`.
  - During reset: `req_ready=0`, all outputs 0.
  - In the first cycle after release: `req_ready=4'b0001`.
- **Single frame:** `req_valid=4'b0001`, word 0 = 4'b1011.
  - One-cycle `req_ready[0]`.
  - Next 4 cycles: `serial_out` = 1,1,0,1 with `serial_valid=1` and `frame_start` on the first bit only.
  - `grant_id=0`, then 1 GAP cycle, then IDLE.
- **Full load:** all four valid continuously with words 0x1, 0x2, 0x4, 0x8.
  - Grants in order 0, 1, 2, 3, 0, with accepts exactly 6 cycles apart.
  - Serial streams are 1000, 0100, 0010, 0001 (LSB-first).
- **Fairness:** grant requester 2, then hold `req_valid=4'b1001`.
  - Next grant is 3, then 0.
- **Reset mid-frame:**
  - Setup: requester 1 is granted; assert `reset` after its 2nd bit.
  - Required response: `serial_valid=0` from the next cycle, with no further bits from that frame.
  - Follow-up: release reset, then assert `req_valid=4'b1010` → requester 1 is granted first, because `last` was reset to 3.
- **GAP=0 instance:** continuous valid on requesters 0 and 1.
  - Accepts are 5 cycles apart and grants alternate 0, 1.
  - `data_in_change`: modify `req_data` during SHIFT → emitted bits still equal the accepted word.
